// File: rtl/dm_unit.sv
// Data-memory stage: sub-word store merge, extended loads, sticky fault capture, debug read.
// Optional access counters are built when DM_PERF_CNT_EN is defined; otherwise ld_cnt/st_cnt read 0.
module dm_unit #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_w,
  input  logic                  mem_r,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  input  logic [2:0]            dm_type,
  output logic [31:0]           rdata,
  output logic                  fault,
  output logic [31:0]           fault_addr,
  input  logic                  fault_clr,
  input  logic [DEPTH_LOG2-1:0] dbg_addr,
  output logic [31:0]           dbg_data,
  output logic [31:0]           ld_cnt,
  output logic [31:0]           st_cnt
);

  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [32:0] SIZE_BYTES = 33'd4 << DEPTH_LOG2;

  logic [31:0]           mem_q [0:DEPTH-1];
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  logic                  in_range, misaligned, type_ok, illegal;
  logic                  st_en;
  logic [31:0]           rd_word, mem_wdata_d, ld_ext;
  logic [15:0]           half_sel;
  logic [7:0]            byte_sel;
  logic                  fault_d, fault_q;
  logic [31:0]           fault_addr_d, fault_addr_q;

  assign off      = addr - BASE_ADDR;
  assign word_idx = off[DEPTH_LOG2+1:2];
  assign lane     = off[1:0];
  assign in_range = {1'b0, off} < SIZE_BYTES;
  assign type_ok  = (dm_type <= 3'b100);

  always_comb begin
    misaligned = 1'b0;
    case (dm_type)
      3'b000:         misaligned = (lane != 2'b00);
      3'b001, 3'b010: misaligned = lane[0];
      default:        misaligned = 1'b0;
    endcase
  end

  assign illegal  = (mem_w | mem_r) & (~in_range | misaligned | ~type_ok);
  assign st_en    = mem_w & ~illegal;
  assign rd_word  = mem_q[word_idx];
  assign dbg_data = mem_q[dbg_addr];

  // Load extraction; rdata reflects pre-write contents when a store shares the cycle.
  always_comb begin
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (lane)
      2'b00:   byte_sel = rd_word[7:0];
      2'b01:   byte_sel = rd_word[15:8];
      2'b10:   byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    case (dm_type)
      3'b000:  ld_ext = rd_word;
      3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
      3'b010:  ld_ext = {16'h0000, half_sel};
      3'b011:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_ext = {24'h000000, byte_sel};
      default: ld_ext = 32'h0;
    endcase
    rdata = (mem_r & ~illegal) ? ld_ext : 32'h0;
  end

  always_comb begin
    mem_wdata_d = rd_word;
    case (dm_type)
      3'b000: mem_wdata_d = wdata;
      3'b001, 3'b010: begin
        if (lane[1]) mem_wdata_d[31:16] = wdata[15:0];
        else         mem_wdata_d[15:0]  = wdata[15:0];
      end
      3'b011, 3'b100: begin
        case (lane)
          2'b00:   mem_wdata_d[7:0]   = wdata[7:0];
          2'b01:   mem_wdata_d[15:8]  = wdata[7:0];
          2'b10:   mem_wdata_d[23:16] = wdata[7:0];
          default: mem_wdata_d[31:24] = wdata[7:0];
        endcase
      end
      default: mem_wdata_d = rd_word;
    endcase
  end

  // The array has no reset: a store coinciding with reset still lands.
  always_ff @(posedge clk) begin
    if (st_en) mem_q[word_idx] <= mem_wdata_d;
  end

  // Clear beats a same-cycle fault; only the first fault address is kept.
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (fault_clr) begin
      fault_d      = 1'b0;
      fault_addr_d = 32'h0;
    end else if (illegal && !fault_q) begin
      fault_d      = 1'b1;
      fault_addr_d = addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

`ifdef DM_PERF_CNT_EN
  logic [31:0] ld_cnt_d, ld_cnt_q, st_cnt_d, st_cnt_q;

  // A combined load+store cycle counts only as a store.
  always_comb begin
    ld_cnt_d = ld_cnt_q + {31'd0, mem_r & ~mem_w & ~illegal};
    st_cnt_d = st_cnt_q + {31'd0, st_en};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ld_cnt_q <= 32'h0;
      st_cnt_q <= 32'h0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  assign ld_cnt = ld_cnt_q;
  assign st_cnt = st_cnt_q;
`else
  assign ld_cnt = 32'h0;
  assign st_cnt = 32'h0;
`endif

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data-memory stage that sits directly downstream of the pipelined core's EX/MEM register. It consumes the MEM-stage address, store data, write strobe, read strobe and access type, and returns load data.
- Performs sub-word store merging and sub-word load extraction with sign or zero extension.
- Flags misaligned and out-of-range accesses in a sticky fault register.
- Provides a debug word-read port and optional access counters.

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (1024 words = 4 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- mem_w  in  1  store strobe from the EX/MEM stage.
- mem_r  in  1  load strobe from the EX/MEM stage.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (forwarded rs2).
- dm_type  in  3  access type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; other codes are illegal.
- rdata  out  32  extended load data, combinational.
- fault  out  1  sticky fault flag.
- fault_addr  out  32  address of the first faulting access.
- fault_clr  in  1  clears fault and fault_addr.
- dbg_addr  in  DEPTH_LOG2  word index for debug read.
- dbg_data  out  32  raw word at dbg_addr, combinational.
- ld_cnt  out  32  completed legal load count.
- st_cnt  out  32  completed legal store count.

Behaviour:
- Offset: off = addr - BASE_ADDR; word index = off[DEPTH_LOG2+1:2]; byte lane = off[1:0].
- In range: off < 4*2^DEPTH_LOG2 (unsigned compare on the full 32 bits).
- Misaligned: word access with off[1:0] != 0, or halfword access with off[0] != 0.
- Illegal access: any of out-of-range, misaligned, or illegal dm_type, while mem_w or mem_r is high.
- Load path (zero latency):
  - rdata is combinational from the array so the core's MEM/WB register samples it at the end of the MEM cycle.
  - Byte loads select the lane from off[1:0]; halfword loads select the lane from off[1].
  - Signed types sign-extend from bit 7 or 15; unsigned types zero-extend.
  - rdata = 0 when mem_r is low or the access is illegal.
- Store path:
  - A legal store commits at the posedge ending the cycle in which mem_w is high.
  - Byte and halfword stores modify only the addressed lanes, taken from wdata[7:0] or wdata[15:0]; the other bytes are preserved.
  - Illegal stores write nothing.
- mem_w and mem_r both high: treated as a store. rdata shows the pre-write contents of that cycle; ld_cnt is not incremented.
- Fault register:
  - On an illegal access, if fault = 0: set fault = 1 and capture fault_addr = addr at the posedge.
  - Later faults do not overwrite fault_addr.
  - fault_clr high at a posedge clears both fault and fault_addr.
  - If fault_clr and a new illegal access occur in the same cycle, clear wins; the new fault is lost.
- Reset (reset = 0 at a posedge): fault = 0, fault_addr = 0, ld_cnt = 0, st_cnt = 0. The memory array is not cleared; its contents are undefined until written.
- Reset mid-operation: a store presented in the same cycle as reset is still committed to the array. The counters read 0 afterwards.
- dbg_data = array[dbg_addr]. Reads are unaffected by fault state; same-cycle writes become visible the following cycle.
- Counters (see Optional Feature):
  - Increment by 1 per legal load or store.
  - Wrap from 32'hFFFF_FFFF to 0.
  - Illegal accesses are not counted.

Optional Feature:
- Macro: DM_PERF_CNT_EN.
- Defined: ld_cnt and st_cnt are implemented as specified above.
- Not defined: the counter registers are omitted; ld_cnt and st_cnt are tied to 32'h0. All other behaviour is identical.

Test Plan:
- Word store, then load: store 32'hDEADBEEF to addr 0x10 (type 000), next cycle load type 000 from 0x10 -> rdata = 32'hDEADBEEF; st_cnt = 1, ld_cnt = 1 (with DM_PERF_CNT_EN).
- Byte merge and extension: after the word above, store byte 0x80 to 0x12 (type 011). Then:
  - load word -> 32'hDE80BEEF;
  - load type 011 at 0x12 -> 32'hFFFFFF80;
  - load type 100 at 0x12 -> 32'h00000080.
- Halfword lanes: store half 0x8001 to 0x16 -> load type 001 at 0x16 = 32'hFFFF8001, type 010 = 32'h00008001; bytes 0x14 and 0x15 are unchanged.
- Misaligned fault: word store to 0x21, then halfword load at 0x23:
  - word at 0x20 is unchanged;
  - rdata = 0;
  - fault = 1, fault_addr = 0x21 (not 0x23);
  - fault_clr pulse -> fault = 0, fault_addr = 0.
- Out-of-range access with DEPTH_LOG2 = 10: store to 0x1000 -> no write, fault = 1, fault_addr = 0x1000. Store to 0xFFC -> written and readable via dbg_addr = 1023.
- Reset mid-run: after 3 stores, hold reset low for one cycle -> counters = 0, fault = 0, and memory contents are retained (check via dbg_data).
